tmr_scrub_ctrl: RTL and testbench

- Scrub controller for the user-project triple-modular-redundant (TMR) register file.
- Sequences read → bitwise 2-of-3 vote → corrective write-back over a programmed address range.
- Arbitrates the single register-file port between the user datapath (absolute priority) and the scrubber.
- Reports progress and corrected-word count on a status field routed by the top level to LA probes and mprj_io.

---
 rtl/tmr_scrub_pkg.sv | 20 ++
 rtl/tmr_vote3.sv | 16 +
 rtl/tmr_scrub_ctrl.sv | 134 +++++++++++++
 tb/tb_tmr_scrub_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmr_scrub_pkg.sv
// Shared encodings for the TMR register-file scrubber: FSM states,
// status field values and the corrected-word counter width.
package tmr_scrub_pkg;

  localparam int ERR_CNT_W = 16;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b01;

  typedef logic [2:0] fsm_state_t;

  localparam fsm_state_t S_IDLE = 3'd0;
  localparam fsm_state_t S_RD   = 3'd1;
  localparam fsm_state_t S_VOTE = 3'd2;
  localparam fsm_state_t S_WR   = 3'd3;
  localparam fsm_state_t S_NEXT = 3'd4;
  localparam fsm_state_t S_DONE = 3'd5;

endpackage

// File: rtl/tmr_vote3.sv
// Bitwise 2-of-3 majority over three redundant copies, plus a flag raised
// when any copy disagrees with the voted word.
module tmr_vote3 #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  output logic [DATA_W-1:0] maj,
  output logic              mism
);

  assign maj  = (a & b) | (a & c) | (b & c);
  assign mism = (a != maj) || (b != maj) || (c != maj);

endmodule

// File: rtl/tmr_scrub_ctrl.sv
// Scrub controller: read / vote / write-back over an address range, yielding the
// register-file port to the user datapath. Optional macro TMR_SCRUB_PERIODIC_EN.
module tmr_scrub_ctrl
  import tmr_scrub_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int PERIOD = 65535
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [ADDR_W-1:0]    first_addr_i,
  input  logic [ADDR_W-1:0]    last_addr_i,
  input  logic                 usr_req_i,
  output logic                 usr_gnt_o,
  output logic [ADDR_W-1:0]    rf_addr_o,
  output logic                 rf_rd_o,
  output logic                 rf_we_o,
  input  logic [DATA_W-1:0]    rf_rdata0_i,
  input  logic [DATA_W-1:0]    rf_rdata1_i,
  input  logic [DATA_W-1:0]    rf_rdata2_i,
  output logic [DATA_W-1:0]    rf_wdata_o,
  output logic [1:0]           status_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  fsm_state_t           state;
  logic                 start_q;
  logic [ADDR_W-1:0]    cur, first_q, last_q;
  logic [ADDR_W-1:0]    nfirst, nlast;
  logic [DATA_W-1:0]    vote, vote_q;
  logic                 mism;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 idle_or_done, start_edge, trig, scan_start;

  tmr_vote3 #(.DATA_W(DATA_W)) u_vote (
    .a    (rf_rdata0_i),
    .b    (rf_rdata1_i),
    .c    (rf_rdata2_i),
    .maj  (vote),
    .mism (mism)
  );

  assign usr_gnt_o    = usr_req_i;
  assign idle_or_done = (state == S_IDLE) || (state == S_DONE);
  assign start_edge   = start_i & ~start_q;

`ifdef TMR_SCRUB_PERIODIC_EN
  localparam int CNT_W = $clog2(PERIOD + 1);
  logic [CNT_W-1:0] per_cnt;
  logic             per_expire;

  assign per_expire = idle_or_done && !abort_i && (per_cnt == CNT_W'(PERIOD - 1));
  assign trig       = start_edge | per_expire;

  // Counts only while parked; any scan start or busy cycle rearms it.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !idle_or_done || scan_start) per_cnt <= '0;
    else if (!abort_i)                          per_cnt <= per_cnt + 1'b1;
  end
`else
  logic [31:0] period_unused;
  assign period_unused = PERIOD;
  assign trig          = start_edge;
`endif

  assign scan_start = trig && idle_or_done && !abort_i && !usr_req_i;
  // A timer restart reuses the last range; a real start edge relatches it.
  assign nfirst     = start_edge ? first_addr_i : first_q;
  assign nlast      = start_edge ? last_addr_i  : last_q;

  assign rf_rd_o    = (state == S_RD) && !usr_req_i && !abort_i && !wb_rst_i;
  assign rf_we_o    = (state == S_WR) && !usr_req_i && !abort_i && !wb_rst_i;
  assign rf_addr_o  = cur;
  assign rf_wdata_o = vote_q;
  assign err_cnt_o  = err_cnt;

  always_comb begin
    status_o = ST_BUSY;
    if (state == S_IDLE)      status_o = ST_IDLE;
    else if (state == S_DONE) status_o = ST_DONE;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= S_IDLE;
      start_q <= 1'b0;
      cur     <= '0;
      first_q <= '0;
      last_q  <= '0;
      vote_q  <= '0;
      err_cnt <= '0;
    end else begin
      start_q <= start_i;
      if (abort_i) begin
        state <= S_IDLE;
      end else if (scan_start) begin
        first_q <= nfirst;
        last_q  <= nlast;
        cur     <= nfirst;
        err_cnt <= '0;
        state   <= (nfirst > nlast) ? S_DONE : S_RD;
      end else begin
        case (state)
          S_RD:   if (!usr_req_i) state <= S_VOTE;
          // A user access between read and write-back may have changed the
          // word, so the vote is dropped and the address is read again.
          S_VOTE: if (usr_req_i) state <= S_RD;
                  else begin
                    vote_q <= vote;
                    state  <= mism ? S_WR : S_NEXT;
                  end
          S_WR:   if (usr_req_i) state <= S_RD;
                  else begin
                    if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                    state <= S_NEXT;
                  end
          S_NEXT: if (!usr_req_i) begin
                    if (cur == last_q) state <= S_DONE;
                    else begin
                      cur   <= cur + 1'b1;
                      state <= S_RD;
                    end
                  end
          S_IDLE, S_DONE: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// Scoreboard bench for tmr_scrub_ctrl: a reference model of the TMR memory
// predicts each scan's reads and corrective writes; a monitor checks strobes.
module tb_tmr_scrub_ctrl;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1, start_i = 1'b0, abort_i = 1'b0, usr_req = 1'b0;
  logic [ADDR_W-1:0] first_a = '0, last_a = '0;
  logic              usr_gnt, rf_rd, rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rd0 = '0, rd1 = '0, rd2 = '0, wdata;
  logic [1:0]        status;
  logic [15:0]       err_cnt;

  tmr_scrub_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PERIOD(50)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start_i), .abort_i(abort_i),
    .first_addr_i(first_a), .last_addr_i(last_a), .usr_req_i(usr_req),
    .usr_gnt_o(usr_gnt), .rf_addr_o(rf_addr), .rf_rd_o(rf_rd), .rf_we_o(rf_we),
    .rf_rdata0_i(rd0), .rf_rdata1_i(rd1), .rf_rdata2_i(rd2),
    .rf_wdata_o(wdata), .status_o(status), .err_cnt_o(err_cnt)
  );

  typedef struct { bit wr; int addr; logic [31:0] data; } ev_t;

  logic [DATA_W-1:0] m0 [DEPTH];
  logic [DATA_W-1:0] m1 [DEPTH];
  logic [DATA_W-1:0] m2 [DEPTH];
  ev_t exp_q[$];
  ev_t e;
  int  n_cmp = 0, n_fail = 0, rereads = 0, last_rd = -1;
  bit  cont_en = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Per-bit majority by counting ones among the three copies.
  function automatic logic [31:0] maj3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = (int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2;
    return r;
  endfunction

  function automatic int count_bad(input int f, input int l);
    int n = 0;
    for (int a = f; a <= l; a++) if (m0[a] !== m1[a] || m1[a] !== m2[a]) n++;
    return n;
  endfunction

  task automatic expect_scan(input int f, input int l, output int nerr);
    logic [31:0] v;
    nerr = 0;
    for (int a = f; a <= l; a++) begin
      exp_q.push_back('{wr: 1'b0, addr: a, data: '0});
      v = maj3(m0[a], m1[a], m2[a]);
      if (m0[a] !== v || m1[a] !== v || m2[a] !== v) begin
        exp_q.push_back('{wr: 1'b1, addr: a, data: v});
        nerr++;
      end
    end
  endtask

  task automatic corrupt_random();
    for (int a = 0; a < DEPTH; a++) begin
      m0[a] = $urandom; m1[a] = m0[a]; m2[a] = m0[a];
      case ($urandom_range(0, 5))
        0: m0[a] = m0[a] ^ ($urandom | 32'h1);
        1: m1[a] = m1[a] ^ ($urandom | 32'h1);
        2: m2[a] = m2[a] ^ ($urandom | 32'h1);
        default: ;
      endcase
    end
  endtask

  // Pulses start, optionally grants the user during the first VOTE cycle,
  // and waits for DONE; ends one cycle into DONE at posedge+1.
  task automatic run_scan(input int f, input int l, input bit cont_vote);
    int  nerr, busy;
    bit  done;
    bit  timed;
    timed = !cont_vote && !cont_en;
    expect_scan(f, l, nerr);
    last_rd = -1; rereads = 0;
    first_a = ADDR_W'(f); last_a = ADDR_W'(l);
    start_i = 1'b1; tick(1); start_i = 1'b0;
    if (cont_vote) begin tick(1); usr_req = 1'b1; tick(1); usr_req = 1'b0; end
    busy = cont_vote ? 2 : 0; done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (status == 2'b10) busy++;
      else if (status == 2'b01) done = 1;
    end
    check("scan_done", done, 1);
    check("err_cnt", err_cnt, nerr);
    check("exp_q_drained", exp_q.size(), 0);
    if (timed) begin
      check("busy_cycles", busy, 3 * (l - f + 1) + nerr);
      check("no_rereads", rereads, 0);
    end
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    int f, l, nerr, exp_err, k;
    bit found;
    fork
      forever begin
        @(negedge clk);
        check("usr_gnt", usr_gnt, usr_req);
        if (usr_req && (rf_rd || rf_we)) check("strobe_in_grant", {rf_rd, rf_we}, 2'b00);
        if (rf_rd || rf_we) begin
          if (rf_rd && rf_we) check("dual_strobe", rf_we, 0);
          else if (rf_rd && last_rd == int'(rf_addr) &&
                   !(exp_q.size() > 0 && !exp_q[0].wr && exp_q[0].addr == int'(rf_addr)))
            rereads++;
          else if (exp_q.size() == 0) check("unexpected_strobe", {rf_rd, rf_we, rf_addr}, 0);
          else begin
            e = exp_q.pop_front();
            check("strobe_kind", rf_we, e.wr);
            check("strobe_addr", rf_addr, e.addr);
            if (e.wr) check("wdata", wdata, e.data);
            else last_rd = e.addr;
          end
          if (rf_rd) begin rd0 = m0[rf_addr]; rd1 = m1[rf_addr]; rd2 = m2[rf_addr]; end
          if (rf_we) begin m0[rf_addr] = wdata; m1[rf_addr] = wdata; m2[rf_addr] = wdata; end
        end
      end
      forever begin
        @(posedge clk); #1;
        if (cont_en) usr_req = (status == 2'b10) && ($urandom_range(0, 3) == 0);
      end
    join_none

    corrupt_random();
    tick(3);
    @(negedge clk);
    check("rst_status", status, 2'b00);
    check("rst_err", err_cnt, 0);
    check("rst_strobes", {rf_rd, rf_we}, 2'b00);
    check("rst_addr", rf_addr, 0);
    check("rst_wdata", wdata, 0);
    @(posedge clk); #1; rst = 1'b0;
    tick(1);

    // Clean 0..3: four reads, no writes, 12 busy cycles.
    for (int a = 0; a < 4; a++) begin m1[a] = m0[a]; m2[a] = m0[a]; end
    run_scan(0, 3, 0);
    check("clean_status", status, 2'b01);

    // Single-copy upset at 5.
    m0[5] = 32'h1; m1[5] = 32'hDEADBEEF; m2[5] = 32'h1;
    run_scan(5, 5, 0);
    check("upset_err", err_cnt, 1);
    check("upset_fixed", m1[5], 32'h1);

    // User grab during VOTE of a corrupted word: one re-read, counted once.
    m2[5] = 32'hFFFF0000;
    run_scan(5, 5, 1);
    check("cont_rereads", rereads, 1);
    check("cont_err", err_cnt, 1);
    check("cont_fixed", m2[5], 32'h1);

    // Top-of-range scan must stop at the last address without wrapping.
    corrupt_random();
    run_scan(28, 31, 0);

    // Random ranges, alternating with random user contention.
    for (int it = 0; it < 8; it++) begin
      corrupt_random();
      cont_en = it[0];
      f = $urandom_range(0, 31); l = $urandom_range(f, 31);
      run_scan(f, l, 0);
    end
    cont_en = 0; usr_req = 1'b0; tick(1);

    // Abort at cur=10 with a simultaneous start edge.
    corrupt_random();
    exp_err = count_bad(0, 9);
    expect_scan(0, 31, nerr);
    last_rd = -1;
    first_a = '0; last_a = 5'd31;
    start_i = 1'b1; tick(1); start_i = 1'b0;
    found = 0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk);
      if (rf_rd && rf_addr == 5'd10) found = 1;
    end
    check("abort_reach_cur10", found, 1);
    @(posedge clk); #1;
    abort_i = 1'b1; start_i = 1'b1;
    @(negedge clk);
    check("abort_no_strobe", {rf_rd, rf_we}, 2'b00);
    @(posedge clk); #1;
    check("abort_status", status, 2'b00);
    check("abort_err_held", err_cnt, exp_err);
    abort_i = 1'b0; start_i = 1'b0;
    exp_q.delete();
    tick(40);
    check("abort_status_stays", status, 2'b00);
    check("abort_err_stays", err_cnt, exp_err);

    // Empty range, then start held high with a new range: no retrigger.
    first_a = 5'd7; last_a = 5'd3;
    start_i = 1'b1; tick(1);
    check("empty_done", status, 2'b01);
    check("empty_err", err_cnt, 0);
    tick(2);
    first_a = 5'd0; last_a = 5'd1;
    tick(100);
    check("held_status", status, 2'b01);
    check("held_err", err_cnt, 0);
    start_i = 1'b0; tick(1);
    run_scan(0, 1, 0);

    // Reset in the middle of a scan.
    corrupt_random();
    expect_scan(0, 31, nerr);
    last_rd = -1;
    first_a = '0; last_a = 5'd31;
    start_i = 1'b1; tick(1); start_i = 1'b0;
    tick(8);
    rst = 1'b1;
    @(negedge clk);
    check("rst_cycle_no_strobe", {rf_rd, rf_we}, 2'b00);
    @(posedge clk); #1;
    check("midrst_status", status, 2'b00);
    check("midrst_err", err_cnt, 0);
    check("midrst_addr", rf_addr, 0);
    rst = 1'b0;
    exp_q.delete();
    tick(5);

`ifdef TMR_SCRUB_PERIODIC_EN
    // Auto rescan 50 cycles after entering DONE, using the latched range.
    corrupt_random();
    run_scan(2, 3, 0);
    expect_scan(2, 3, nerr);
    found = 0; k = 0;
    for (int i = 1; i < 200 && !found; i++) begin
      @(negedge clk);
      if (rf_rd) begin found = 1; k = i; end
    end
    check("periodic_fired", found, 1);
    check("periodic_delay", k, 50);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (status == 2'b01) found = 1;
    end
    check("periodic_done", found, 1);
    check("periodic_err", err_cnt, nerr);
    check("periodic_drained", exp_q.size(), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
